// File: rtl/data_mem_unit.sv
// Data-memory stage: byte/half/word loads and stores with a fixed access latency.
// Optional sticky misalignment flag enabled by defining DMEM_ERR_STICKY_EN.
module data_mem_unit #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [1:0]  size,
    input  logic        LoadUnsigned,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] RAMout,
    output logic        mem_ready,
    output logic        mem_stall,
    output logic        misaligned,
    output logic        err_sticky
);

    localparam int AW = $clog2(DEPTH_WORDS);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state;
    logic [3:0]    cnt;

    logic [AW+1:0] r_addr;
    logic [1:0]    r_size;
    logic [31:0]   r_wdata;
    logic          r_unsigned;
    logic          r_write;

    logic [31:0]   mem [DEPTH_WORDS];

    logic          req;
    logic          finish;
    logic [AW+1:0] c_addr;
    logic [1:0]    c_size;
    logic [31:0]   c_wdata;
    logic          c_unsigned;
    logic          c_write;
    logic          c_mis;
    logic [AW-1:0] c_idx;
    logic [3:0]    be;
    logic [31:0]   wd;
    logic [31:0]   rd_word;
    logic [7:0]    rd_byte;
    logic [15:0]   rd_half;
    logic [31:0]   ld_val;

    assign req       = MemRead | MemWrite;
    assign mem_stall = ((state == IDLE) && req) || (state == BUSY);

    // With LATENCY==1 the access completes straight out of IDLE, so the
    // commit path reads the live inputs rather than the request registers.
    assign finish = ((state == IDLE) && req && (LATENCY == 1)) ||
                    ((state == BUSY) && (cnt == 4'd1));

    always_comb begin
        if (state == IDLE) begin
            c_addr     = addr[AW+1:0];
            c_size     = size;
            c_wdata    = wdata;
            c_unsigned = LoadUnsigned;
            c_write    = MemWrite;
        end else begin
            c_addr     = r_addr;
            c_size     = r_size;
            c_wdata    = r_wdata;
            c_unsigned = r_unsigned;
            c_write    = r_write;
        end
    end

    assign c_idx = c_addr[AW+1:2];
    assign c_mis = ((c_size == 2'b01) && c_addr[0]) ||
                   (c_size[1] && (c_addr[1:0] != 2'b00));

    // Sub-word store data is replicated across lanes; enables pick the lane.
    always_comb begin
        be = 4'b0000;
        wd = c_wdata;
        case (c_size)
            2'b00: begin
                be = 4'b0001 << c_addr[1:0];
                wd = {4{c_wdata[7:0]}};
            end
            2'b01: begin
                be = c_addr[1] ? 4'b1100 : 4'b0011;
                wd = {2{c_wdata[15:0]}};
            end
            default: begin
                be = 4'b1111;
                wd = c_wdata;
            end
        endcase
    end

    assign rd_word = mem[c_idx];
    assign rd_byte = rd_word[8*c_addr[1:0] +: 8];
    assign rd_half = c_addr[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        case (c_size)
            2'b00:   ld_val = c_unsigned ? {24'd0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
            2'b01:   ld_val = c_unsigned ? {16'd0, rd_half} : {{16{rd_half[15]}}, rd_half};
            default: ld_val = rd_word;
        endcase
    end

    // Memory contents survive reset; the rst gate keeps an in-reset request from committing.
    always_ff @(posedge clk) begin
        if (!rst && finish && c_write && !c_mis) begin
            for (int k = 0; k < 4; k++) begin
                if (be[k]) mem[c_idx][8*k +: 8] <= wd[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            RAMout     <= 32'd0;
            mem_ready  <= 1'b0;
            misaligned <= 1'b0;
            r_addr     <= '0;
            r_size     <= 2'b00;
            r_wdata    <= 32'd0;
            r_unsigned <= 1'b0;
            r_write    <= 1'b0;
        end else begin
            mem_ready  <= finish;
            misaligned <= finish && c_mis;
            if (finish && !c_write) RAMout <= c_mis ? 32'd0 : ld_val;
            case (state)
                IDLE: begin
                    if (req) begin
                        r_addr     <= addr[AW+1:0];
                        r_size     <= size;
                        r_wdata    <= wdata;
                        r_unsigned <= LoadUnsigned;
                        r_write    <= MemWrite;
                        if (LATENCY > 1) begin
                            state <= BUSY;
                            cnt   <= 4'(LATENCY - 1);
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                BUSY: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DMEM_ERR_STICKY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                err_sticky <= 1'b0;
        else if (finish && c_mis) err_sticky <= 1'b1;
    end
`else
    assign err_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_data_mem_unit.sv
// Randomized bench for data_mem_unit against a byte-array reference model.
module tb_data_mem_unit;

    localparam int LAT = 2;
    localparam int DW  = 256;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemRead, MemWrite, LoadUnsigned;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    logic [31:0] RAMout;
    logic        mem_ready, mem_stall, misaligned, err_sticky;

    data_mem_unit #(.DEPTH_WORDS(DW), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite),
        .size(size), .LoadUnsigned(LoadUnsigned), .addr(addr), .wdata(wdata),
        .RAMout(RAMout), .mem_ready(mem_ready), .mem_stall(mem_stall),
        .misaligned(misaligned), .err_sticky(err_sticky)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0]  ref_mem [4*DW];
    logic [31:0] ref_ram;
    logic        ref_sticky;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic exp_sticky();
`ifdef DMEM_ERR_STICKY_EN
        return ref_sticky;
`else
        return 1'b0;
`endif
    endfunction

    // Model: memory is a flat little-endian byte array, index = addr mod 4*DW.
    task automatic model(input logic wr, input logic [1:0] sz, input logic lu,
                         input logic [31:0] a, input logic [31:0] wd, output logic mis);
        int bi, hi, wi;
        logic [7:0]  b;
        logic [15:0] h;
        bi = int'(a % (4*DW));
        hi = bi & ~1;
        wi = bi & ~3;
        mis = (sz == 2'd1 && a[0]) || (sz >= 2'd2 && a[1:0] != 2'd0);
        if (mis) ref_sticky = 1'b1;
        if (wr) begin
            if (!mis) begin
                if (sz == 2'd0) ref_mem[bi] = wd[7:0];
                else if (sz == 2'd1) begin
                    ref_mem[hi] = wd[7:0]; ref_mem[hi+1] = wd[15:8];
                end else
                    for (int k = 0; k < 4; k++) ref_mem[wi+k] = wd[8*k +: 8];
            end
        end else if (mis) begin
            ref_ram = 32'd0;
        end else if (sz == 2'd0) begin
            b = ref_mem[bi];
            ref_ram = lu ? {24'd0, b} : {{24{b[7]}}, b};
        end else if (sz == 2'd1) begin
            h = {ref_mem[hi+1], ref_mem[hi]};
            ref_ram = lu ? {16'd0, h} : {{16{h[15]}}, h};
        end else begin
            ref_ram = {ref_mem[wi+3], ref_mem[wi+2], ref_mem[wi+1], ref_mem[wi]};
        end
    endtask

    // Entered just after a rising edge; returns just after the edge following DONE.
    task automatic access(input logic rd, input logic wr, input logic [1:0] sz,
                          input logic lu, input logic [31:0] a, input logic [31:0] wd);
        logic mis;
        int   cyc;
        MemRead = rd; MemWrite = wr; size = sz; LoadUnsigned = lu; addr = a; wdata = wd;
        model(wr, sz, lu, a, wd, mis);
        #1;
        chk("stall_req", {31'd0, mem_stall}, 32'd1);
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
            if (!mem_ready && cyc < LAT) chk("stall_busy", {31'd0, mem_stall}, 32'd1);
        end while (!mem_ready && cyc < LAT + 6);
        chk("latency",    32'(cyc), 32'(LAT));
        chk("ready",      {31'd0, mem_ready}, 32'd1);
        chk("stall_done", {31'd0, mem_stall}, 32'd0);
        chk("misaligned", {31'd0, misaligned}, {31'd0, mis});
        chk("ramout",     RAMout, ref_ram);
        chk("sticky",     {31'd0, err_sticky}, {31'd0, exp_sticky()});
        MemRead = 1'b0; MemWrite = 1'b0;
        @(posedge clk); #1;
        chk("ready_pulse", {31'd0, mem_ready}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; size = 2'd0;
        LoadUnsigned = 1'b0; addr = 32'd0; wdata = 32'd0;
        ref_ram = 32'd0; ref_sticky = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ramout", RAMout, 32'd0);
        chk("rst_ready",  {31'd0, mem_ready}, 32'd0);
        chk("rst_mis",    {31'd0, misaligned}, 32'd0);
        chk("rst_sticky", {31'd0, err_sticky}, 32'd0);
        chk("rst_stall",  {31'd0, mem_stall}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Fill every word so later loads never see uninitialised data.
        for (int w = 0; w < DW; w++) access(1'b0, 1'b1, 2'd2, 1'b0, 32'(w * 4), $urandom);

        access(1'b0, 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF);
        access(1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        chk("plan_word", RAMout, 32'hDEADBEEF);

        access(1'b0, 1'b1, 2'd2, 1'b0, 32'h20, 32'h80FF7F01);
        access(1'b1, 1'b0, 2'd0, 1'b0, 32'h23, 32'h0);
        chk("plan_lb", RAMout, 32'hFFFFFF80);
        access(1'b1, 1'b0, 2'd0, 1'b1, 32'h23, 32'h0);
        chk("plan_lbu", RAMout, 32'h00000080);
        access(1'b1, 1'b0, 2'd1, 1'b0, 32'h22, 32'h0);
        chk("plan_lh", RAMout, 32'hFFFF80FF);

        access(1'b0, 1'b1, 2'd2, 1'b0, 32'h20, 32'h11223344);
        access(1'b0, 1'b1, 2'd0, 1'b0, 32'h21, 32'h000000AA);
        chk("plan_hold", RAMout, 32'hFFFF80FF);
        access(1'b1, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
        chk("plan_sb", RAMout, 32'h1122AA44);

        access(1'b1, 1'b0, 2'd2, 1'b0, 32'h06, 32'h0);
        chk("plan_mis", RAMout, 32'h0);

        // Reset during BUSY: the store is dropped, RAMout clears immediately.
        access(1'b1, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
        MemWrite = 1'b1; size = 2'd2; addr = 32'h30; wdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        chk("busy_stall", {31'd0, mem_stall}, 32'd1);
        rst = 1'b1;
        #1;
        chk("async_ramout", RAMout, 32'd0);
        chk("async_sticky", {31'd0, err_sticky}, 32'd0);
        MemWrite = 1'b0;
        ref_ram = 32'd0; ref_sticky = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        access(1'b1, 1'b0, 2'd2, 1'b0, 32'h30, 32'h0);

        access(1'b0, 1'b1, 2'd2, 1'b0, 32'h400, 32'h5A5AC3C3);
        access(1'b1, 1'b0, 2'd2, 1'b0, 32'h000, 32'h0);
        chk("plan_wrap", RAMout, 32'h5A5AC3C3);

        access(1'b1, 1'b1, 2'd2, 1'b0, 32'h44, 32'h0BADCAFE);
        chk("both_no_load", RAMout, 32'h5A5AC3C3);
        access(1'b1, 1'b0, 2'd2, 1'b0, 32'h44, 32'h0);
        chk("both_store", RAMout, 32'h0BADCAFE);

        for (int i = 0; i < 300; i++) begin
            logic rd, wr;
            rd = 1'($urandom);
            wr = 1'($urandom);
            if (!rd && !wr) rd = 1'b1;
            access(rd, wr, 2'($urandom), 1'($urandom), $urandom, $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
